// File: rtl/plic_claim_sequencer.sv
// Hart-side PLIC controller: programs IE/threshold/priority after reset, then runs
// claim -> ID read -> CPU hand-off -> complete for one interrupt at a time.
module plic_claim_sequencer #(
  parameter int                       NUM_SRC    = 5,
  parameter int                       ID_W       = 3,
  parameter logic [NUM_SRC-1:0]       INIT_IE    = 5'h1F,
  parameter logic [ID_W-1:0]          INIT_THR   = 3'd0,
  parameter logic [NUM_SRC*ID_W-1:0]  INIT_PRIO  = 15'h2C1,
  parameter int                       CLAIM_WAIT = 2
) (
  input  logic            clk_i,
  input  logic            resetn_i,
  output logic            avm_chipselect_o,
  output logic            avm_write_o,
  output logic            avm_read_o,
  output logic [1:0]      avm_address_o,
  output logic [31:0]     avm_writedata_o,
  input  logic [31:0]     avm_readdata_i,
  input  logic            plic_notify_i,
  output logic            plic_claim_o,
  output logic            plic_complete_o,
  output logic            cpu_irq_o,
  output logic [ID_W-1:0] cpu_irq_id_o,
  input  logic            cpu_ack_i,
  input  logic            cpu_eoi_i,
  output logic            init_done_o,
  output logic [7:0]      spurious_cnt_o
);

  typedef enum logic [3:0] {
    S_INIT_IE,
    S_INIT_THR,
    S_INIT_PRIO,
    S_IDLE,
    S_CLAIM,
    S_WAIT,
    S_READ,
    S_CAPTURE,
    S_PRESENT,
    S_SERVICE,
    S_COMPLETE
  } state_t;

  localparam logic [1:0] ADDR_IE    = 2'd0;
  localparam logic [1:0] ADDR_THR   = 2'd1;
  localparam logic [1:0] ADDR_PRIO  = 2'd2;
  localparam logic [1:0] ADDR_ID    = 2'd3;
  localparam logic [3:0] WAIT_LAST  = 4'(CLAIM_WAIT - 1);

  state_t          r_state;
  logic [3:0]      r_wait_cnt;
  logic            r_cs;
  logic            r_wr;
  logic            r_rd;
  logic [1:0]      r_addr;
  logic [31:0]     r_wdata;
  logic [ID_W-1:0] r_irq_id;
  logic [7:0]      r_spur_cnt;
  logic            r_init_done;

  // Only the ID field of the claim register is meaningful.
  logic w_unused_rdata;
  assign w_unused_rdata = ^avm_readdata_i[31:ID_W];

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; the async reset clears all state so an abort never leaves a pulse behind.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_state     <= S_INIT_IE;
      r_wait_cnt  <= 4'd0;
      r_cs        <= 1'b0;
      r_wr        <= 1'b0;
      r_rd        <= 1'b0;
      r_addr      <= 2'd0;
      r_wdata     <= 32'd0;
      r_irq_id    <= '0;
      r_spur_cnt  <= 8'd0;
      r_init_done <= 1'b0;
    end else begin
      r_cs <= 1'b0;
      r_wr <= 1'b0;
      r_rd <= 1'b0;
      case (r_state)
        S_INIT_IE: begin
          r_cs    <= 1'b1;
          r_wr    <= 1'b1;
          r_addr  <= ADDR_IE;
          r_wdata <= 32'(INIT_IE);
          r_state <= S_INIT_THR;
        end
        S_INIT_THR: begin
          r_cs    <= 1'b1;
          r_wr    <= 1'b1;
          r_addr  <= ADDR_THR;
          r_wdata <= 32'(INIT_THR);
          r_state <= S_INIT_PRIO;
        end
        S_INIT_PRIO: begin
          r_cs    <= 1'b1;
          r_wr    <= 1'b1;
          r_addr  <= ADDR_PRIO;
          r_wdata <= 32'(INIT_PRIO);
          r_state <= S_IDLE;
        end
        S_IDLE: begin
          // Claiming waits until the last init write has left the bus.
          r_init_done <= 1'b1;
          if (plic_notify_i && r_init_done) r_state <= S_CLAIM;
        end
        S_CLAIM: begin
          r_wait_cnt <= 4'd0;
          r_state    <= S_WAIT;
        end
        S_WAIT: begin
          if (r_wait_cnt == WAIT_LAST) begin
            r_cs    <= 1'b1;
            r_rd    <= 1'b1;
            r_addr  <= ADDR_ID;
            r_state <= S_READ;
          end else begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
          end
        end
        S_READ: begin
          r_state <= S_CAPTURE;
        end
        S_CAPTURE: begin
          r_irq_id <= avm_readdata_i[ID_W-1:0];
          if (avm_readdata_i[ID_W-1:0] == '0) begin
            if (r_spur_cnt != 8'hFF) r_spur_cnt <= r_spur_cnt + 8'd1;
            r_state <= S_COMPLETE;
          end else begin
            r_state <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (cpu_ack_i && cpu_eoi_i) r_state <= S_COMPLETE;
          else if (cpu_ack_i)         r_state <= S_SERVICE;
        end
        S_SERVICE: begin
          if (cpu_eoi_i) r_state <= S_COMPLETE;
        end
        S_COMPLETE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_INIT_IE;
        end
      endcase
    end
  end

  assign avm_chipselect_o = r_cs;
  assign avm_write_o      = r_wr;
  assign avm_read_o       = r_rd;
  assign avm_address_o    = r_addr;
  assign avm_writedata_o  = r_wdata;
  assign plic_claim_o     = (r_state == S_CLAIM);
  assign plic_complete_o  = (r_state == S_COMPLETE);
  assign cpu_irq_o        = (r_state == S_PRESENT);
  assign cpu_irq_id_o     = r_irq_id;
  assign init_done_o      = r_init_done;
  assign spurious_cnt_o   = r_spur_cnt;

endmodule

// File: tb/tb_plic_claim_sequencer.sv
// Directed bench for plic_claim_sequencer: init writes, claim/hand-off/complete,
// spurious counting with saturation, ack+eoi shortcut and reset abort.
module tb_plic_claim_sequencer;

  logic        clk_i;
  logic        resetn_i;
  logic        avm_chipselect_o;
  logic        avm_write_o;
  logic        avm_read_o;
  logic [1:0]  avm_address_o;
  logic [31:0] avm_writedata_o;
  logic [31:0] avm_readdata_i;
  logic        plic_notify_i;
  logic        plic_claim_o;
  logic        plic_complete_o;
  logic        cpu_irq_o;
  logic [2:0]  cpu_irq_id_o;
  logic        cpu_ack_i;
  logic        cpu_eoi_i;
  logic        init_done_o;
  logic [7:0]  spurious_cnt_o;

  int n_total = 0;
  int n_bad   = 0;

  plic_claim_sequencer dut (
    .clk_i            (clk_i),
    .resetn_i         (resetn_i),
    .avm_chipselect_o (avm_chipselect_o),
    .avm_write_o      (avm_write_o),
    .avm_read_o       (avm_read_o),
    .avm_address_o    (avm_address_o),
    .avm_writedata_o  (avm_writedata_o),
    .avm_readdata_i   (avm_readdata_i),
    .plic_notify_i    (plic_notify_i),
    .plic_claim_o     (plic_claim_o),
    .plic_complete_o  (plic_complete_o),
    .cpu_irq_o        (cpu_irq_o),
    .cpu_irq_id_o     (cpu_irq_id_o),
    .cpu_ack_i        (cpu_ack_i),
    .cpu_eoi_i        (cpu_eoi_i),
    .init_done_o      (init_done_o),
    .spurious_cnt_o   (spurious_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance one cycle; inputs and samples settle 1ns after the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic sel_bit(input int sel);
    case (sel)
      0:       return plic_claim_o;
      1:       return plic_complete_o;
      default: return cpu_irq_o;
    endcase
  endfunction

  task automatic wait_sig(input string tag, input int sel, input int bound);
    int k;
    k = 0;
    while (sel_bit(sel) !== 1'b1 && k < bound) begin
      tick();
      k++;
    end
    check(tag, 32'(sel_bit(sel)), 32'd1);
  endtask

  task automatic check_bus(input string tag, input logic cs, input logic wr, input logic rd,
                           input logic [1:0] addr, input logic [31:0] data);
    check({tag, "_cs"},    32'(avm_chipselect_o), 32'(cs));
    check({tag, "_wr"},    32'(avm_write_o),      32'(wr));
    check({tag, "_rd"},    32'(avm_read_o),       32'(rd));
    check({tag, "_addr"},  32'(avm_address_o),    32'(addr));
    check({tag, "_wdata"}, avm_writedata_o,       data);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_bus(tag, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
    check({tag, "_claim"}, 32'(plic_claim_o),    32'd0);
    check({tag, "_cplt"},  32'(plic_complete_o), 32'd0);
    check({tag, "_irq"},   32'(cpu_irq_o),       32'd0);
    check({tag, "_id"},    32'(cpu_irq_id_o),    32'd0);
    check({tag, "_done"},  32'(init_done_o),     32'd0);
    check({tag, "_spur"},  32'(spurious_cnt_o),  32'd0);
  endtask

  // Release reset mid-cycle and follow the three init writes to IDLE.
  task automatic run_init(input string tag);
    resetn_i = 1'b1;
    tick();
    check_bus({tag, "_w0"}, 1'b1, 1'b1, 1'b0, 2'd0, 32'h1F);
    check({tag, "_c1_claim"}, 32'(plic_claim_o), 32'd0);
    tick();
    check_bus({tag, "_w1"}, 1'b1, 1'b1, 1'b0, 2'd1, 32'h0);
    check({tag, "_c2_done"}, 32'(init_done_o), 32'd0);
    tick();
    check_bus({tag, "_w2"}, 1'b1, 1'b1, 1'b0, 2'd2, 32'h2C1);
    check({tag, "_c3_claim"}, 32'(plic_claim_o), 32'd0);
    tick();
    check({tag, "_c4_done"}, 32'(init_done_o), 32'd1);
    check({tag, "_c4_cs"}, 32'(avm_chipselect_o), 32'd0);
    check({tag, "_c4_claim"}, 32'(plic_claim_o), 32'd0);
  endtask

  initial begin
    int  n_spur;
    logic irq_seen;

    resetn_i       = 1'b0;
    plic_notify_i  = 1'b0;
    cpu_ack_i      = 1'b0;
    cpu_eoi_i      = 1'b0;
    avm_readdata_i = 32'd0;
    tick();
    tick();
    check_reset_outputs("rst");

    // Notify already high during init must wait for IDLE; PLIC will return ID 3.
    plic_notify_i  = 1'b1;
    avm_readdata_i = 32'hFFFF_FFF3;
    run_init("init");

    // Cycle 4 is IDLE with notify high: claim at 5, read at 8, irq at 10.
    tick();
    check("t2_claim", 32'(plic_claim_o), 32'd1);
    tick();
    check("t2_claim_1cyc", 32'(plic_claim_o), 32'd0);
    plic_notify_i = 1'b0;
    tick();
    check("t2_wait_rd", 32'(avm_read_o), 32'd0);
    tick();
    check_bus("t2_read", 1'b1, 1'b0, 1'b1, 2'd3, 32'h2C1);
    tick();
    check("t2_cap_rd", 32'(avm_read_o), 32'd0);
    check("t2_cap_irq", 32'(cpu_irq_o), 32'd0);
    tick();
    check("t2_irq", 32'(cpu_irq_o), 32'd1);
    check("t2_id", 32'(cpu_irq_id_o), 32'd3);
    cpu_eoi_i = 1'b1;
    tick();
    cpu_eoi_i = 1'b0;
    check("t2_eoi_ignored", 32'(cpu_irq_o), 32'd1);
    check("t2_eoi_no_cplt", 32'(plic_complete_o), 32'd0);
    cpu_ack_i = 1'b1;
    tick();
    cpu_ack_i = 1'b0;
    check("t2_ack_irq_low", 32'(cpu_irq_o), 32'd0);
    check("t2_svc_id", 32'(cpu_irq_id_o), 32'd3);
    tick();
    check("t2_svc_no_cplt", 32'(plic_complete_o), 32'd0);
    cpu_eoi_i = 1'b1;
    tick();
    cpu_eoi_i = 1'b0;
    check("t2_cplt", 32'(plic_complete_o), 32'd1);
    check("t2_cplt_id", 32'(cpu_irq_id_o), 32'd3);
    tick();
    check("t2_cplt_1cyc", 32'(plic_complete_o), 32'd0);
    tick();
    check("t2_no_reclaim", 32'(plic_claim_o), 32'd0);

    // ack and eoi together in PRESENT go straight to COMPLETE.
    avm_readdata_i = 32'd5;
    plic_notify_i  = 1'b1;
    wait_sig("t4_claim_seen", 0, 8);
    plic_notify_i = 1'b0;
    wait_sig("t4_irq_seen", 2, 10);
    check("t4_id", 32'(cpu_irq_id_o), 32'd5);
    cpu_ack_i = 1'b1;
    cpu_eoi_i = 1'b1;
    tick();
    cpu_ack_i = 1'b0;
    cpu_eoi_i = 1'b0;
    check("t4_cplt", 32'(plic_complete_o), 32'd1);
    check("t4_irq_low", 32'(cpu_irq_o), 32'd0);
    tick();
    check("t4_cplt_1cyc", 32'(plic_complete_o), 32'd0);

    // Spurious ID 0: no irq, counter increments, complete issued, re-claim after one IDLE cycle.
    avm_readdata_i = 32'hFFFF_FFF8;
    plic_notify_i  = 1'b1;
    wait_sig("t3_claim_seen", 0, 8);
    irq_seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      irq_seen = irq_seen | cpu_irq_o;
    end
    check("t3_no_irq", 32'(irq_seen), 32'd0);
    check("t3_cplt", 32'(plic_complete_o), 32'd1);
    check("t3_spur1", 32'(spurious_cnt_o), 32'd1);
    tick();
    check("t5_idle_gap", 32'(plic_claim_o), 32'd0);
    tick();
    check("t5_reclaim", 32'(plic_claim_o), 32'd1);
    for (n_spur = 2; n_spur <= 256; n_spur++) begin
      wait_sig("t3_loop_cplt", 1, 12);
      if (n_spur == 254) check("t3_spur254", 32'(spurious_cnt_o), 32'd254);
      if (n_spur == 255) check("t3_spur255", 32'(spurious_cnt_o), 32'd255);
      if (n_spur == 256) check("t3_spur_sat", 32'(spurious_cnt_o), 32'd255);
      if (n_spur == 256) plic_notify_i = 1'b0;
      tick();
    end
    tick();
    check("t3_idle_claim", 32'(plic_claim_o), 32'd0);

    // Reset during SERVICE aborts immediately with no complete pulse.
    avm_readdata_i = 32'd6;
    plic_notify_i  = 1'b1;
    wait_sig("t6_claim_seen", 0, 8);
    plic_notify_i = 1'b0;
    wait_sig("t6_irq_seen", 2, 10);
    cpu_ack_i = 1'b1;
    tick();
    cpu_ack_i = 1'b0;
    check("t6_service", 32'(cpu_irq_o), 32'd0);
    #2;
    resetn_i = 1'b0;
    #1;
    check_reset_outputs("t6_abort");
    tick();
    check("t6_no_cplt", 32'(plic_complete_o), 32'd0);
    run_init("t6_reinit");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
